b11_param: RTL and testbench



---
 rtl/b11_param_if.sv | 30 +++
 rtl/b11_param.sv | 169 ++++++++++++++++
 tb/tb_b11_param.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/b11_param_if.sv
// Symbol/result bus of the b11_param scrambler.
// drop_cnt exists only when B11_DROP_CNT_EN is defined.
interface b11_param_if #(
  parameter int W = 6
);
  logic [W-1:0] x_in;
  logic         stbi;
  logic [W-1:0] x_out;
  logic         out_valid;
  logic         busy;
`ifdef B11_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  modport master (
    output x_in, stbi,
    input  x_out, out_valid, busy
`ifdef B11_DROP_CNT_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  x_in, stbi,
    output x_out, out_valid, busy
`ifdef B11_DROP_CNT_EN
    , output drop_cnt
`endif
  );
endinterface

// File: rtl/b11_param.sv
// b11_param: parametrised b11 scrambler with output-valid strobe, busy flag and bounded reduction loops.
// Define B11_DROP_CNT_EN to add a saturating rejected-symbol counter on bus.drop_cnt.
module b11_param #(
  parameter int W   = 6,
  parameter int MOD = 26,
  parameter int K00 = 21,
  parameter int K01 = 42,
  parameter int K10 = 7,
  parameter int K11 = 28
) (
  input  logic       clock,
  input  logic       reset,
  b11_param_if.slave bus
);
  localparam int AW = W + 3;

  localparam logic signed [AW-1:0] MOD_S  = AW'(MOD);
  localparam logic signed [AW-1:0] K00_S  = AW'(K00);
  localparam logic signed [AW-1:0] K01_S  = AW'(K01);
  localparam logic signed [AW-1:0] K10_S  = AW'(K10);
  localparam logic signed [AW-1:0] K11_S  = AW'(K11);
  localparam logic [W-1:0]         MOD_M1 = W'(MOD - 1);

  typedef enum logic [3:0] {
    S_RESET, S_DATAIN, S_SPAZIO, S_MUL, S_SOMMA, S_RSUM, S_RSOT, S_COMPL, S_DATAOUT
  } state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           r_in_q, r_in_d;
  logic [W-1:0]           cont_q, cont_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [1:0]             iter_q, iter_d;
  logic [W-1:0]           x_out_q, x_out_d;
  logic                   out_valid_q, out_valid_d;

  function automatic logic signed [AW-1:0] zext(input logic [W-1:0] v);
    return {3'b000, v};
  endfunction

  // Magnitude of the signed accumulator, truncated to the symbol width.
  function automatic logic [W-1:0] abs_trunc(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] m;
    m = v[AW-1] ? -v : v;
    return m[W-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    r_in_d      = r_in_q;
    cont_d      = cont_q;
    acc_d       = acc_q;
    iter_d      = iter_q;
    x_out_d     = x_out_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      S_RESET: begin
        cont_d  = '0;
        r_in_d  = bus.x_in;
        x_out_d = '0;
        state_d = S_DATAIN;
      end
      S_DATAIN: begin
        r_in_d  = bus.x_in;
        state_d = bus.stbi ? S_DATAIN : S_SPAZIO;
      end
      S_SPAZIO: begin
        if (r_in_q == '0 || r_in_q == '1) begin
          cont_d  = (cont_q < MOD_M1) ? cont_q + W'(1) : '0;
          acc_d   = zext(r_in_q);
          state_d = S_DATAOUT;
        end else if (zext(r_in_q) <= MOD_S) begin
          state_d = S_MUL;
        end else begin
          state_d = S_DATAIN;
        end
      end
      S_MUL: begin
        acc_d   = r_in_q[0] ? (zext(cont_q) << 1) : zext(cont_q);
        state_d = S_SOMMA;
      end
      S_SOMMA: begin
        iter_d = '0;
        if (r_in_q[1]) begin
          acc_d   = zext(r_in_q) + acc_q;
          state_d = S_RSUM;
        end else begin
          acc_d   = zext(r_in_q) - acc_q;
          state_d = S_RSOT;
        end
      end
      // Both reduction loops are capped at two passes; legal operands never need more.
      S_RSUM: begin
        if (acc_q > MOD_S && iter_q != 2'd2) begin
          acc_d  = acc_q - MOD_S;
          iter_d = iter_q + 2'd1;
        end else begin
          state_d = S_COMPL;
        end
      end
      S_RSOT: begin
        if (acc_q[AW-1] && iter_q != 2'd2) begin
          acc_d  = acc_q + MOD_S;
          iter_d = iter_q + 2'd1;
        end else begin
          state_d = S_COMPL;
        end
      end
      S_COMPL: begin
        unique case (r_in_q[3:2])
          2'b00:   acc_d = acc_q - K00_S;
          2'b01:   acc_d = acc_q - K01_S;
          2'b10:   acc_d = acc_q + K10_S;
          default: acc_d = acc_q + K11_S;
        endcase
        state_d = S_DATAOUT;
      end
      S_DATAOUT: begin
        x_out_d     = abs_trunc(acc_q);
        out_valid_d = 1'b1;
        state_d     = S_DATAIN;
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_RESET;
      r_in_q      <= '0;
      cont_q      <= '0;
      acc_q       <= '0;
      iter_q      <= '0;
      x_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_in_q      <= r_in_d;
      cont_q      <= cont_d;
      acc_q       <= acc_d;
      iter_q      <= iter_d;
      x_out_q     <= x_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.x_out     = x_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != S_DATAIN);

`ifdef B11_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;
  logic       reject;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign reject = (state_q == S_SPAZIO) && (r_in_q != '0) && (r_in_q != '1)
                  && (zext(r_in_q) > MOD_S);
  assign drop_d = reject ? sat_inc(drop_q) : drop_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign bus.drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_b11_param.sv
// Bench for b11_param: transaction-level reference model checked every cycle, plus directed literal cases.
module tb_b11_param;
  localparam int W   = 6;
  localparam int MOD = 26;
  localparam int K00 = 21;
  localparam int K01 = 42;
  localparam int K10 = 7;
  localparam int K11 = 28;

  logic clock = 1'b0;
  logic reset = 1'b0;

  b11_param_if #(.W(W)) bus();

  b11_param #(.W(W), .MOD(MOD), .K00(K00), .K01(K01), .K10(K10), .K11(K11)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state: one accepted symbol is in flight for 'lat' edges.
  bit m_rst  = 1'b1;
  bit m_idle = 1'b0;
  bit m_out  = 1'b0;
  int m_cnt  = 0;
  int m_cont = 0;
  int m_res  = 0;
  int m_drop = 0;
  int e_x    = 0;
  bit e_vld  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Result of one symbol from the arithmetic rules; lat = edges from acceptance to result.
  function automatic void model_sym(input int sym, input int cont, output int res, output int lat,
                                    output bit has_out, output int cont_n);
    int a;
    int n;
    cont_n  = cont;
    res     = 0;
    has_out = 1'b1;
    lat     = 1;
    if (sym == 0 || sym == (1 << W) - 1) begin
      cont_n = (cont + 1) % MOD;
      res    = sym;
      lat    = 2;
    end else if (sym > MOD) begin
      has_out = 1'b0;
    end else begin
      a = ((sym & 1) != 0) ? 2 * cont : cont;
      n = 0;
      if ((sym & 2) != 0) begin
        a = sym + a;
        while (a > MOD && n < 2) begin a -= MOD; n++; end
      end else begin
        a = sym - a;
        while (a < 0 && n < 2) begin a += MOD; n++; end
      end
      case ((sym >> 2) & 3)
        0:       a -= K00;
        1:       a -= K01;
        2:       a += K10;
        default: a += K11;
      endcase
      if (a < 0) a = -a;
      res = a % (1 << W);
      lat = 6 + n;
    end
  endfunction

  initial forever begin
    int res, lat, cn;
    bit ho;
    @(posedge clock or posedge reset);
    e_vld = 1'b0;
    if (reset) begin
      m_rst = 1'b1; m_idle = 1'b0; m_cnt = 0; m_cont = 0; e_x = 0; m_drop = 0;
    end else if (m_rst) begin
      m_rst = 1'b0; m_idle = 1'b1; e_x = 0;
    end else if (m_idle) begin
      if (!bus.stbi) begin
        model_sym(int'(bus.x_in), m_cont, res, lat, ho, cn);
        m_cont = cn; m_res = res; m_out = ho; m_cnt = lat; m_idle = 1'b0;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_idle = 1'b1;
        if (m_out) begin
          e_x   = m_res;
          e_vld = 1'b1;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      check("busy", 32'(bus.busy), m_idle ? 32'd0 : 32'd1);
      check("out_valid", 32'(bus.out_valid), 32'(e_vld));
      check("x_out", 32'(bus.x_out), 32'(e_x));
`ifdef B11_DROP_CNT_EN
      check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
`endif
    end
  end

  task automatic do_reset();
    #2 reset = 1'b1;
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic run_sym(input int x, input int lat, input int lit, input string nm);
    bus.x_in = W'(x);
    bus.stbi = 1'b0;
    @(negedge clock);
    bus.stbi = 1'b1;
    bus.x_in = W'($urandom);
    repeat (lat - 1) @(negedge clock);
    check({nm, "_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    check({nm, "_vld"}, 32'(bus.out_valid), 32'd1);
    check({nm, "_x"}, 32'(bus.x_out), 32'(lit));
  endtask

  initial begin
    int res, lat, cn, sel;
    bit ho;
    bus.x_in = '0;
    bus.stbi = 1'b1;

    model_sym(6, 1, res, lat, ho, cn);
    check("pin_model_6", 32'(res), 32'd35);
    model_sym(23, 13, res, lat, ho, cn);
    check("pin_model_23", 32'(res), 32'd19);
    check("pin_model_23_lat", 32'(lat), 32'd7);

    do_reset();
    chk_en = 1'b1;
    check("rst_x_out", 32'(bus.x_out), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    run_sym(0, 2, 0, "zero");
    run_sym(6, 6, 35, "sym6_c1");
    run_sym(63, 2, 63, "ones");
    run_sym(5, 6, 41, "sym5_c2");

    // Reset while the sum loop is active.
    bus.x_in = W'(6);
    bus.stbi = 1'b0;
    @(negedge clock);
    bus.stbi = 1'b1;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_x_out", 32'(bus.x_out), 32'd0);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd1);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    run_sym(6, 6, 36, "after_rst");

    // Rejected symbol: no pulse, x_out holds.
    bus.x_in = W'(30);
    bus.stbi = 1'b0;
    @(negedge clock);
    bus.stbi = 1'b1;
    check("rej_v0", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    check("rej_v1", 32'(bus.out_valid), 32'd0);
    check("rej_hold", 32'(bus.x_out), 32'd36);
`ifdef B11_DROP_CNT_EN
    check("drop_one", 32'(bus.drop_cnt), 32'd1);
`endif
    bus.stbi = 1'b0;
    repeat (512) @(negedge clock);
    bus.stbi = 1'b1;
    @(negedge clock);
    check("rej_many_hold", 32'(bus.x_out), 32'd36);
`ifdef B11_DROP_CNT_EN
    check("drop_sat", 32'(bus.drop_cnt), 32'd255);
`endif

    // Counter wrap, then cont=13 with a one-pass sum loop.
    do_reset();
    for (int i = 0; i < 39; i++) run_sym(0, 2, 0, "zero_run");
    run_sym(15, 7, 43, "sym15_c13");

    for (int i = 0; i < 4000; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       bus.x_in = '0;
        1:       bus.x_in = '1;
        2, 3, 4, 5, 6: bus.x_in = W'($urandom_range(1, MOD));
        default: bus.x_in = W'($urandom_range(0, (1 << W) - 1));
      endcase
      bus.stbi = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
      end
      @(negedge clock);
    end
    bus.stbi = 1'b1;
    repeat (10) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
